sysbus_fetch_unit: RTL and testbench
====================================

// Module: sysbus_fetch_unit
// PURPOSE
//  Core-side instruction fetcher; the Sysbus Top-side master inside Core, directly upstream of SysbusBottom.
//  Issues one read per 64-byte line starting at the entry point and collects LINE_BEATS response beats.
//  Streams aligned 8-byte fetch words with their PC to the decoder over a valid/ready handshake.
//  Handles redirects (branches): the in-flight line is completed on the bus and squashed.
// PARAMETERS
//  DATA_WIDTH   64     bus beat width in bits; also the fetch word width
//  TAG_WIDTH    13     bus tag width; tag[12] = 1 for read, tag[11:0] = transaction id
//  LINE_BEATS   8      beats per line; line = LINE_BEATS*DATA_WIDTH/8 = 64 bytes
//  FETCH_ID     12'h001  transaction id carried in tag[11:0] of every fetch read
// PORTS
//  clk            in   1           clock
//  reset          in   1           synchronous, active-high
//  entry          in   64          initial fetch PC, sampled in the first cycle after reset
//  redirect_valid in   1           one-cycle pulse: restart fetch at redirect_pc
//  redirect_pc    in   64          new fetch PC
//  req            out  DATA_WIDTH  line address {pc[63:6],6'b0}
//  reqtag         out  TAG_WIDTH   {1'b1, FETCH_ID}
//  reqcyc         out  1           request valid
//  reqack         in   1           bus accepted the request this cycle
//  resp           in   DATA_WIDTH  response beat
//  resptag        in   TAG_WIDTH   response tag
//  respcyc        in   1           response beat valid
//  respack        out  1           beat consumed this cycle
//  out_valid      out  1           fetch word valid
//  out_data       out  DATA_WIDTH  aligned 8-byte word at out_pc[63:3]
//  out_pc         out  64          PC of the word (low 3 bits preserved from the redirect/entry)
//  out_ready      in   1           decoder accepts the word
// BEHAVIOUR
//  - States: IDLE, REQ, WAIT, DRAIN. Reset: state=IDLE, beat_cnt=0, squash=0, pend=0.
//    Outputs under reset: reqcyc=0, respack=0, out_valid=0, req=0.
//  - IDLE: fetch_pc<=entry, go to REQ. Exactly one IDLE cycle after reset deasserts.
//  - REQ: reqcyc=1. req/reqtag are stable until the cycle reqack=1. On reqack go to WAIT, beat_cnt<=0.
//  - WAIT: respack = respcyc & (resptag=={1,FETCH_ID}), combinational.
//    A beat with a non-matching tag is not acked and is ignored.
//    Each acked beat writes line[beat_cnt], then beat_cnt++.
//    On the last beat (beat_cnt==LINE_BEATS-1 acked):
//      squash=0 -> go to DRAIN.
//      squash=1 -> fetch_pc<=pend_pc, squash<=0, go to REQ; the line is discarded.
//  - DRAIN: out_valid=1, out_data=line[fetch_pc[5:3]], out_pc=fetch_pc.
//    On out_ready: fetch_pc<={fetch_pc[63:3]+1,3'b0}.
//    If fetch_pc[5:3]==7, the next-line address wraps into pc[63:6]; go to REQ. Otherwise stay.
//    fetch_pc wraps modulo 2^64 with no error.
//  - Redirect in DRAIN: fetch_pc<=redirect_pc, go to REQ, out_valid drops the next cycle.
//    If out_ready and redirect_valid coincide, the current word is consumed and the redirect wins the PC update.
//  - Redirect in REQ (not yet acked): request address held, pend_pc<=redirect_pc, squash<=1.
//    Redirect in WAIT: same latching.
//    Multiple redirects before the squash resolves: the last one wins.
//    Redirect in the same cycle as the last beat: treat it as squash. Complete to REQ at redirect_pc.
//  - Redirect in IDLE is ignored (entry takes precedence).
//  - Exactly one outstanding request; reqcyc is never asserted in WAIT/DRAIN.
//  - Reset mid-transaction: abandon the line and return to IDLE. The bus shares the reset, so no stale beats return.
// STRUCTURE
//  - sysbus_pkg: SYSBUS_TAG_READ bit index, fetch_state_t enum, LINE_BEATS/LINE_BYTES constants.
//    Also a make_tag(rd,id) function.
//  - Sub-module fetch_line_buffer: LINE_BEATS x DATA_WIDTH register array with write port (beat_cnt, resp, respack) and read port (index).
//  - FSM, counters and redirect latch live in sysbus_fetch_unit.
// TESTING
//  1. entry=0x1008, reset 2 cycles, reqack on first REQ cycle:
//     req=0x1000, reqtag=0x1001. Send 8 beats D0..D7 -> out_pc=0x1008, out_data=D1, then 0x1010..0x1038 (D2..D7).
//     Next req=0x1040.
//  2. reqack held low 5 cycles -> req/reqtag/reqcyc stable all 5 cycles; WAIT entered only after the ack.
//  3. Interleave beats tagged 0x1002 with valid beats -> respack=0 on foreign tags; line holds only the matching data in order.
//  4. redirect_pc=0x2000 pulsed after the 3rd beat -> all 8 beats still acked, no out_valid.
//     Next req=0x2000; first out_pc=0x2000.
//  5. In DRAIN, out_ready=0 for 4 cycles -> out_data/out_pc stable.
//     Then redirect 0x3004 with out_ready=1 -> next req=0x3000; first out_pc=0x3004.
//  6. reset asserted in WAIT after 4 beats -> next cycle reqcyc=0, out_valid=0.
//     After release, req=entry line address.

Source files
------------

// File: rtl/sysbus_pkg.sv
// Shared Sysbus definitions for the core-side fetch path: tag layout,
// fetch FSM encoding and line geometry.
package sysbus_pkg;

  localparam int SYSBUS_TAG_WIDTH = 13;
  localparam int SYSBUS_TAG_READ  = 12;
  localparam int LINE_BEATS       = 8;
  localparam int LINE_BYTES       = LINE_BEATS * 8;

  typedef enum logic [1:0] {
    FETCH_IDLE  = 2'd0,
    FETCH_REQ   = 2'd1,
    FETCH_WAIT  = 2'd2,
    FETCH_DRAIN = 2'd3
  } fetch_state_t;

  // Tag layout: read flag in the top bit, transaction id below it.
  function automatic logic [SYSBUS_TAG_WIDTH-1:0] make_tag(input logic rd,
                                                            input logic [SYSBUS_TAG_READ-1:0] id);
    logic [SYSBUS_TAG_WIDTH-1:0] t;
    t = '0;
    t[SYSBUS_TAG_READ] = rd;
    t[SYSBUS_TAG_READ-1:0] = id;
    return t;
  endfunction

endpackage

// File: rtl/fetch_line_buffer.sv
// One cache line of response beats: written beat by beat from the bus,
// read combinationally by word index.
module fetch_line_buffer
  import sysbus_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int LINE_BEATS = 8,
  parameter int IDX_W      = $clog2(LINE_BEATS)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [IDX_W-1:0]      waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [IDX_W-1:0]      raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [LINE_BEATS];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sysbus_fetch_unit.sv
// Core-side instruction fetcher: reads whole lines over Sysbus and streams
// aligned fetch words to the decoder, squashing lines made stale by redirects.
module sysbus_fetch_unit
  import sysbus_pkg::*;
#(
  parameter int          DATA_WIDTH = 64,
  parameter int          TAG_WIDTH  = 13,
  parameter int          LINE_BEATS = 8,
  parameter logic [11:0] FETCH_ID   = 12'h001
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [63:0]           entry,
  input  logic                  redirect_valid,
  input  logic [63:0]           redirect_pc,
  output logic [DATA_WIDTH-1:0] req,
  output logic [TAG_WIDTH-1:0]  reqtag,
  output logic                  reqcyc,
  input  logic                  reqack,
  input  logic [DATA_WIDTH-1:0] resp,
  input  logic [TAG_WIDTH-1:0]  resptag,
  input  logic                  respcyc,
  output logic                  respack,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [63:0]           out_pc,
  input  logic                  out_ready
);

  localparam int IDX_W    = $clog2(LINE_BEATS);
  localparam int LINE_OFF = IDX_W + 3;

  localparam logic [1:0] ST_IDLE  = FETCH_IDLE;
  localparam logic [1:0] ST_REQ   = FETCH_REQ;
  localparam logic [1:0] ST_WAIT  = FETCH_WAIT;
  localparam logic [1:0] ST_DRAIN = FETCH_DRAIN;

  localparam logic [TAG_WIDTH-1:0] FETCH_TAG = TAG_WIDTH'(make_tag(1'b1, FETCH_ID));

  logic [1:0]       state;
  logic [63:0]      fetch_pc;
  logic [63:0]      pend_pc;
  logic             squash;
  logic [IDX_W-1:0] beat_cnt;
  logic [63:0]      line_addr;
  logic             last_beat;
  logic             last_word;

  assign line_addr = {fetch_pc[63:LINE_OFF], {LINE_OFF{1'b0}}};
  assign last_beat = respack && (beat_cnt == IDX_W'(LINE_BEATS - 1));
  assign last_word = (fetch_pc[3 +: IDX_W] == {IDX_W{1'b1}});

  // Bus-facing outputs are forced quiet while reset is held.
  assign reqcyc    = !reset && (state == ST_REQ);
  assign req       = reqcyc ? DATA_WIDTH'(line_addr) : '0;
  assign reqtag    = FETCH_TAG;
  assign respack   = !reset && (state == ST_WAIT) && respcyc && (resptag == FETCH_TAG);
  assign out_valid = !reset && (state == ST_DRAIN);
  assign out_pc    = fetch_pc;

  fetch_line_buffer #(
    .DATA_WIDTH(DATA_WIDTH),
    .LINE_BEATS(LINE_BEATS)
  ) u_line (
    .clk  (clk),
    .we   (respack),
    .waddr(beat_cnt),
    .wdata(resp),
    .raddr(fetch_pc[3 +: IDX_W]),
    .rdata(out_data)
  );

  // A redirect while a request is outstanding is parked in pend_pc; the line
  // still completes on the bus and is then thrown away.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      beat_cnt <= '0;
      squash   <= 1'b0;
      pend_pc  <= '0;
      fetch_pc <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          fetch_pc <= entry;
          state    <= ST_REQ;
        end
        ST_REQ: begin
          if (redirect_valid) begin
            pend_pc <= redirect_pc;
            squash  <= 1'b1;
          end
          if (reqack) begin
            beat_cnt <= '0;
            state    <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (redirect_valid) begin
            pend_pc <= redirect_pc;
            squash  <= 1'b1;
          end
          if (respack) begin
            beat_cnt <= beat_cnt + 1'b1;
          end
          if (last_beat) begin
            if (squash || redirect_valid) begin
              fetch_pc <= redirect_valid ? redirect_pc : pend_pc;
              squash   <= 1'b0;
              state    <= ST_REQ;
            end else begin
              state <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (redirect_valid) begin
            fetch_pc <= redirect_pc;
            state    <= ST_REQ;
          end else if (out_ready) begin
            fetch_pc <= {fetch_pc[63:3] + 61'd1, 3'b000};
            if (last_word) begin
              state <= ST_REQ;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sysbus_fetch_unit.sv
// Directed bench for sysbus_fetch_unit: line fetch, stalls, foreign tags,
// redirects (mid-line, in drain, on the last beat) and reset mid-transaction.
module tb_sysbus_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] entry;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic [63:0] req;
  logic [12:0] reqtag;
  logic        reqcyc;
  logic        reqack;
  logic [63:0] resp;
  logic [12:0] resptag;
  logic        respcyc;
  logic        respack;
  logic        out_valid;
  logic [63:0] out_data;
  logic [63:0] out_pc;
  logic        out_ready;

  int compared   = 0;
  int mismatched = 0;

  localparam logic [12:0] TAG_OK  = 13'h1001;
  localparam logic [12:0] TAG_BAD = 13'h1002;

  sysbus_fetch_unit dut (
    .clk           (clk),
    .reset         (reset),
    .entry         (entry),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .req           (req),
    .reqtag        (reqtag),
    .reqcyc        (reqcyc),
    .reqack        (reqack),
    .resp          (resp),
    .resptag       (resptag),
    .respcyc       (respcyc),
    .respack       (respack),
    .out_valid     (out_valid),
    .out_data      (out_data),
    .out_pc        (out_pc),
    .out_ready     (out_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] beatData(input int ln, input int i);
    return 64'hA5A5_0000_0000_0000 + (64'(ln) << 16) + 64'(i);
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic cyc, input logic [12:0] tag, input logic [63:0] data);
    respcyc = cyc;
    resptag = tag;
    resp    = data;
  endtask

  task automatic sendBeat(input logic [63:0] data, input logic [12:0] tag, input logic expAck,
                          input string name);
    applyStimulus(1'b1, tag, data);
    #1;
    checkOutput(name, 64'(respack), 64'(expAck));
    step();
    applyStimulus(1'b0, 13'h0, 64'h0);
  endtask

  task automatic ackReq();
    reqack = 1'b1;
    step();
    reqack = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    entry = 64'h1008;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    reqack = 1'b0;
    out_ready = 1'b0;
    applyStimulus(1'b0, 13'h0, 64'h0);

    // Reset values and the single IDLE cycle.
    step();
    step();
    checkOutput("rst_reqcyc", 64'(reqcyc), 64'd0);
    checkOutput("rst_respack", 64'(respack), 64'd0);
    checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_req", req, 64'h0);
    reset = 1'b0;
    #1;
    checkOutput("idle_reqcyc", 64'(reqcyc), 64'd0);
    step();
    checkOutput("s1_reqcyc", 64'(reqcyc), 64'd1);
    checkOutput("s1_req", req, 64'h1000);
    checkOutput("s1_reqtag", 64'(reqtag), 64'h1001);
    ackReq();
    #1;
    checkOutput("s1_wait_reqcyc", 64'(reqcyc), 64'd0);
    for (int i = 0; i < 8; i++) sendBeat(beatData(1, i), TAG_OK, 1'b1, "s1_respack");
    out_ready = 1'b1;
    for (int k = 1; k < 8; k++) begin
      #1;
      checkOutput("s1_out_valid", 64'(out_valid), 64'd1);
      checkOutput("s1_out_pc", out_pc, 64'h1000 + 64'(8 * k));
      checkOutput("s1_out_data", out_data, beatData(1, k));
      step();
    end
    out_ready = 1'b0;
    #1;
    checkOutput("s1_next_reqcyc", 64'(reqcyc), 64'd1);
    checkOutput("s1_next_req", req, 64'h1040);

    // Held-off acknowledge keeps the request stable.
    for (int c = 0; c < 5; c++) begin
      #1;
      checkOutput("s2_reqcyc", 64'(reqcyc), 64'd1);
      checkOutput("s2_req", req, 64'h1040);
      checkOutput("s2_reqtag", 64'(reqtag), 64'h1001);
      step();
    end
    ackReq();
    #1;
    checkOutput("s2_wait_reqcyc", 64'(reqcyc), 64'd0);

    // Foreign-tagged beats are ignored.
    for (int i = 0; i < 8; i++) begin
      sendBeat(64'hDEAD_0000_0000_0000 + 64'(i), TAG_BAD, 1'b0, "s3_foreign_ack");
      sendBeat(beatData(2, i), TAG_OK, 1'b1, "s3_respack");
    end
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      #1;
      checkOutput("s3_out_pc", out_pc, 64'h1040 + 64'(8 * k));
      checkOutput("s3_out_data", out_data, beatData(2, k));
      step();
    end
    out_ready = 1'b0;
    #1;
    checkOutput("s3_next_req", req, 64'h1080);

    // Redirect mid-line squashes the line once it completes.
    ackReq();
    for (int i = 0; i < 3; i++) sendBeat(beatData(3, i), TAG_OK, 1'b1, "s4_respack");
    redirect_valid = 1'b1;
    redirect_pc = 64'h2000;
    step();
    redirect_valid = 1'b0;
    for (int i = 3; i < 8; i++) begin
      sendBeat(beatData(3, i), TAG_OK, 1'b1, "s4_respack");
      checkOutput("s4_no_out_valid", 64'(out_valid), 64'd0);
    end
    #1;
    checkOutput("s4_squash_out_valid", 64'(out_valid), 64'd0);
    checkOutput("s4_reqcyc", 64'(reqcyc), 64'd1);
    checkOutput("s4_req", req, 64'h2000);
    ackReq();
    for (int i = 0; i < 8; i++) sendBeat(beatData(4, i), TAG_OK, 1'b1, "s4b_respack");
    #1;
    checkOutput("s4_out_pc", out_pc, 64'h2000);
    checkOutput("s4_out_data", out_data, beatData(4, 0));

    // Decoder stall, then redirect coinciding with out_ready.
    for (int c = 0; c < 4; c++) begin
      #1;
      checkOutput("s5_stall_pc", out_pc, 64'h2000);
      checkOutput("s5_stall_data", out_data, beatData(4, 0));
      step();
    end
    out_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 64'h3004;
    step();
    out_ready = 1'b0;
    redirect_valid = 1'b0;
    #1;
    checkOutput("s5_out_valid_drop", 64'(out_valid), 64'd0);
    checkOutput("s5_req", req, 64'h3000);
    ackReq();
    for (int i = 0; i < 8; i++) sendBeat(beatData(5, i), TAG_OK, 1'b1, "s5_respack");
    #1;
    checkOutput("s5_out_pc", out_pc, 64'h3004);
    checkOutput("s5_out_data", out_data, beatData(5, 0));

    // Redirect arriving together with the last beat.
    redirect_valid = 1'b1;
    redirect_pc = 64'h4000;
    step();
    redirect_valid = 1'b0;
    #1;
    checkOutput("s7_req", req, 64'h4000);
    ackReq();
    for (int i = 0; i < 7; i++) sendBeat(beatData(6, i), TAG_OK, 1'b1, "s7_respack");
    redirect_valid = 1'b1;
    redirect_pc = 64'h5010;
    sendBeat(beatData(6, 7), TAG_OK, 1'b1, "s7_last_respack");
    redirect_valid = 1'b0;
    #1;
    checkOutput("s7_out_valid", 64'(out_valid), 64'd0);
    checkOutput("s7_reqcyc", 64'(reqcyc), 64'd1);
    checkOutput("s7_req_after", req, 64'h5000);
    ackReq();
    for (int i = 0; i < 8; i++) sendBeat(beatData(7, i), TAG_OK, 1'b1, "s7b_respack");
    #1;
    checkOutput("s7_out_pc", out_pc, 64'h5010);
    checkOutput("s7_out_data", out_data, beatData(7, 2));

    // Reset in the middle of a line.
    redirect_valid = 1'b1;
    redirect_pc = 64'h6000;
    step();
    redirect_valid = 1'b0;
    ackReq();
    for (int i = 0; i < 4; i++) sendBeat(beatData(8, i), TAG_OK, 1'b1, "s6_respack");
    reset = 1'b1;
    entry = 64'h7777_0048;
    step();
    checkOutput("s6_rst_reqcyc", 64'(reqcyc), 64'd0);
    checkOutput("s6_rst_out_valid", 64'(out_valid), 64'd0);
    step();
    reset = 1'b0;
    #1;
    checkOutput("s6_idle_reqcyc", 64'(reqcyc), 64'd0);
    step();
    checkOutput("s6_reqcyc", 64'(reqcyc), 64'd1);
    checkOutput("s6_req", req, 64'h7777_0040);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
